// File: rtl/pbtn_debounce_n.sv
`default_nettype none
// ============================================================================
// Module   : pbtn_debounce_n
// Purpose  : N-channel pushbutton conditioner: 2-flop sync, optional inversion,
//            tick-based debounce, press/release strobes, optional auto-repeat
//            (auto-repeat built only when PBTN_AUTOREPEAT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module pbtn_debounce_n #(
    parameter int                  NUM_BTNS        = 6,
    parameter int                  CLK_FREQ_HZ     = 100_000_000,
    parameter int                  SIMULATE        = 0,
    parameter int                  DEBOUNCE_MS     = 5,
    parameter int                  REPEAT_DELAY_MS = 500,
    parameter int                  REPEAT_RATE_MS  = 100,
    parameter logic [NUM_BTNS-1:0] ACTIVE_LOW_MASK = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_BTNS-1:0] pbtn_in,
    output logic [NUM_BTNS-1:0] pbtn_db,
    output logic [NUM_BTNS-1:0] pbtn_rise,
    output logic [NUM_BTNS-1:0] pbtn_fall,
    output logic [NUM_BTNS-1:0] pbtn_rpt,
    output logic                any_event
);

    localparam int            P       = (SIMULATE != 0) ? 4 : CLK_FREQ_HZ / 1000;
    localparam int            PW      = (P > 1) ? $clog2(P) : 1;
    localparam int            DW      = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(P - 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_MS - 1);

`ifdef PBTN_AUTOREPEAT_EN
    localparam int            RMAX       = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int            RW         = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY_MS - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE_MS - 1);

    typedef enum logic [1:0] {
        RPT_IDLE  = 2'd0,
        RPT_DELAY = 2'd1,
        RPT_RATE  = 2'd2
    } rpt_state_t;
`endif

    // Empty block whose name surfaces in elaboration output for bad parameters
    if (NUM_BTNS < 1 || NUM_BTNS > 32 || DEBOUNCE_MS < 1 ||
        REPEAT_DELAY_MS < 1 || REPEAT_RATE_MS < 1) begin : g_param_range_violation
    end

    logic [NUM_BTNS-1:0] sync_q1;
    logic [NUM_BTNS-1:0] sync_q2;
    logic [NUM_BTNS-1:0] s;
    logic [PW-1:0]       pcnt;
    logic                tick;

    // Sync flops reset to the released pin level so reset release is silent
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1 <= ACTIVE_LOW_MASK;
            sync_q2 <= ACTIVE_LOW_MASK;
        end else begin
            sync_q1 <= pbtn_in;
            sync_q2 <= sync_q1;
        end
    end

    assign s    = sync_q2 ^ ACTIVE_LOW_MASK;
    assign tick = (pcnt == P_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pcnt <= '0;
        else
            pcnt <= tick ? '0 : pcnt + PW'(1);
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_chan
        logic [DW-1:0] cnt;
        logic          db_q;
        logic          rise_q;
        logic          fall_q;
        logic          flip;

        assign flip = tick && (s[i] != db_q) && (cnt == DB_LAST);

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt    <= '0;
                db_q   <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= flip & s[i];
                fall_q <= flip & ~s[i];
                if (s[i] == db_q) begin
                    cnt <= '0;
                end else if (tick) begin
                    if (cnt == DB_LAST) begin
                        db_q <= s[i];
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + DW'(1);
                    end
                end
            end
        end

        assign pbtn_db[i]   = db_q;
        assign pbtn_rise[i] = rise_q;
        assign pbtn_fall[i] = fall_q;

`ifdef PBTN_AUTOREPEAT_EN
        rpt_state_t    state;
        rpt_state_t    state_n;
        logic [RW-1:0] rcnt;
        logic [RW-1:0] rcnt_n;
        logic          rpt_q;
        logic          rpt_n;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state <= RPT_IDLE;
                rcnt  <= '0;
                rpt_q <= 1'b0;
            end else begin
                state <= state_n;
                rcnt  <= rcnt_n;
                rpt_q <= rpt_n;
            end
        end

        // A release wins over a due repeat in the same cycle
        always_comb begin
            state_n = state;
            rcnt_n  = rcnt;
            rpt_n   = 1'b0;
            if (flip && !s[i]) begin
                state_n = RPT_IDLE;
                rcnt_n  = '0;
            end else begin
                case (state)
                    RPT_IDLE: begin
                        if (flip) begin
                            state_n = RPT_DELAY;
                            rcnt_n  = '0;
                        end
                    end
                    RPT_DELAY, RPT_RATE: begin
                        if (tick) begin
                            if (rcnt == ((state == RPT_DELAY) ? DELAY_LAST : RATE_LAST)) begin
                                rpt_n   = 1'b1;
                                rcnt_n  = '0;
                                state_n = RPT_RATE;
                            end else begin
                                rcnt_n = rcnt + RW'(1);
                            end
                        end
                    end
                    default: begin
                        state_n = RPT_IDLE;
                        rcnt_n  = '0;
                    end
                endcase
            end
        end

        assign pbtn_rpt[i] = rpt_q;
`else
        assign pbtn_rpt[i] = 1'b0;
`endif
    end

    assign any_event = |{pbtn_rise, pbtn_fall, pbtn_rpt};

endmodule
`default_nettype wire

// File: tb/tb_pbtn_debounce_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_pbtn_debounce_n
// Purpose  : Scoreboard bench for pbtn_debounce_n (P=4, DEBOUNCE_MS=3, 4 channels)
// Revision : 1.0 - initial release
// ============================================================================
module tb_pbtn_debounce_n;

    logic       clk;
    logic       reset;
    logic [3:0] pbtn_in;
    logic [3:0] pbtn_db;
    logic [3:0] pbtn_rise;
    logic [3:0] pbtn_fall;
    logic [3:0] pbtn_rpt;
    logic       any_event;

    int errors = 0;
    int checks = 0;
    int cyc;

    typedef struct {
        int       cyc;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] rpt;
    } ev_t;

    ev_t exp_q[$];
    ev_t ev;

    pbtn_debounce_n #(
        .NUM_BTNS        (4),
        .CLK_FREQ_HZ     (100_000_000),
        .SIMULATE        (1),
        .DEBOUNCE_MS     (3),
        .REPEAT_DELAY_MS (5),
        .REPEAT_RATE_MS  (2),
        .ACTIVE_LOW_MASK (4'b0100)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pbtn_in   (pbtn_in),
        .pbtn_db   (pbtn_db),
        .pbtn_rise (pbtn_rise),
        .pbtn_fall (pbtn_fall),
        .pbtn_rpt  (pbtn_rpt),
        .any_event (any_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge count since reset release; prescaler ticks take effect on edges 4,8,12,...
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push(input int c, input logic [3:0] r, input logic [3:0] f, input logic [3:0] p);
        exp_q.push_back('{c, r, f, p});
    endtask

    task automatic push_rpt(input int c, input logic [3:0] p);
`ifdef PBTN_AUTOREPEAT_EN
        push(c, 4'b0000, 4'b0000, p);
`else
        if (p == 4'b1111) push(c, 4'b0000, 4'b0000, 4'b0000);
`endif
    endtask

    // Monitor: every strobe cycle must match the next expected event exactly
    always @(negedge clk) begin
        if (reset && (any_event || (|pbtn_rise) || (|pbtn_fall) || (|pbtn_rpt))) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d rise=%b fall=%b rpt=%b any=%b required=none",
                         cyc, pbtn_rise, pbtn_fall, pbtn_rpt, any_event);
            end else begin
                ev = exp_q.pop_front();
                if (ev.cyc != cyc || ev.rise !== pbtn_rise || ev.fall !== pbtn_fall ||
                    ev.rpt !== pbtn_rpt || any_event !== 1'b1) begin
                    errors++;
                    $display("FAIL strobe_event actual cyc=%0d rise=%b fall=%b rpt=%b any=%b required cyc=%0d rise=%b fall=%b rpt=%b any=1",
                             cyc, pbtn_rise, pbtn_fall, pbtn_rpt, any_event, ev.cyc, ev.rise, ev.fall, ev.rpt);
                end
            end
        end
    end

    initial begin
        reset   = 1'b0;
        pbtn_in = 4'b0000;
        repeat (8) begin
            @(negedge clk);
            pbtn_in = 4'($urandom_range(0, 15));
            chk("reset_outputs", {pbtn_db, pbtn_rise, pbtn_fall, pbtn_rpt, any_event}, 32'd0);
        end
        pbtn_in = 4'b0100;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        at_cyc(100);
        chk("idle_db", pbtn_db, 4'b0000);

        // Clean press/release on ch0
        pbtn_in[0] = 1'b1;
        push(112, 4'b0001, 4'b0000, 4'b0000);
        push_rpt(132, 4'b0001);
        push_rpt(140, 4'b0001);
        at_cyc(120);
        chk("ch0_db_held", pbtn_db, 4'b0001);
        at_cyc(130);
        pbtn_in[0] = 1'b0;
        push(144, 4'b0000, 4'b0001, 4'b0000);
        at_cyc(150);
        chk("ch0_db_released", pbtn_db, 4'b0000);

        // Bounce on ch1 every 3 cycles, then settle high
        for (int k = 0; k < 14; k++) begin
            at_cyc(160 + 3 * k);
            pbtn_in[1] = ~k[0];
        end
        at_cyc(200);
        chk("ch1_db_bouncing", pbtn_db, 4'b0000);
        at_cyc(202);
        pbtn_in[1] = 1'b1;
        push(216, 4'b0010, 4'b0000, 4'b0000);
        push_rpt(236, 4'b0010);
        push_rpt(244, 4'b0010);
        at_cyc(230);
        chk("ch1_db_settled", pbtn_db, 4'b0010);
        at_cyc(240);
        pbtn_in[1] = 1'b0;
        push(252, 4'b0000, 4'b0010, 4'b0000);

        // Active-low ch2
        at_cyc(260);
        chk("ch2_active_low_idle", pbtn_db, 4'b0000);
        pbtn_in[2] = 1'b0;
        push(272, 4'b0100, 4'b0000, 4'b0000);
        push_rpt(292, 4'b0100);
        push_rpt(300, 4'b0100);
        push_rpt(308, 4'b0100);
        at_cyc(290);
        chk("ch2_db_pressed", pbtn_db, 4'b0100);
        at_cyc(302);
        pbtn_in[2] = 1'b1;
        push(316, 4'b0000, 4'b0100, 4'b0000);

        // Simultaneous ch0+ch3 press, staggered releases
        at_cyc(330);
        pbtn_in[0] = 1'b1;
        pbtn_in[3] = 1'b1;
        push(344, 4'b1001, 4'b0000, 4'b0000);
        push_rpt(364, 4'b1001);
        push_rpt(372, 4'b1001);
        push_rpt(380, 4'b1001);
        at_cyc(360);
        chk("ch0_ch3_db", pbtn_db, 4'b1001);
        at_cyc(370);
        pbtn_in[0] = 1'b0;
        push(384, 4'b0000, 4'b0001, 4'b0000);
        push_rpt(388, 4'b1000);
        push_rpt(396, 4'b1000);
        at_cyc(390);
        pbtn_in[3] = 1'b0;
        push(404, 4'b0000, 4'b1000, 4'b0000);

        // Reset mid-count on ch1 while it stays pressed
        at_cyc(420);
        chk("all_released_db", pbtn_db, 4'b0000);
        pbtn_in[1] = 1'b1;
        at_cyc(426);
        chk("queue_drained_before_reset", exp_q.size(), 32'd0);
        reset = 1'b0;
        #1;
        chk("midcount_reset_outputs", {pbtn_db, pbtn_rise, pbtn_fall, pbtn_rpt, any_event}, 32'd0);
        repeat (3) @(negedge clk);
        chk("reset_hold_db", pbtn_db, 4'b0000);
        push(12, 4'b0010, 4'b0000, 4'b0000);
        push_rpt(32, 4'b0010);
        push_rpt(40, 4'b0010);
        push_rpt(48, 4'b0010);
        reset = 1'b1;
        at_cyc(20);
        chk("post_reset_db", pbtn_db, 4'b0010);
        at_cyc(44);
        pbtn_in[1] = 1'b0;
        push(56, 4'b0000, 4'b0010, 4'b0000);
        at_cyc(70);
        chk("final_db", pbtn_db, 4'b0000);
        chk("queue_drained_final", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
